// File: rtl/alu_seq_pkg.sv
// Shared constants, state/decode types and helper functions for the ALU sequencer.
package alu_seq_pkg;

    localparam int N = 16;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] MOV_IMM = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL1 = 2'b01;
    localparam logic [1:0] SH_LSR1 = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_V = 2;

    typedef enum logic [2:0] {
        S_IDLE, S_GET_A, S_GET_B, S_EXEC, S_WRITE, S_WIMM
    } state_t;

    // Instruction class: selects the FSM path and the ALU opcode.
    typedef enum logic [2:0] {
        K_ALU, K_CMP, K_MOVR, K_MOVI, K_ILL
    } kind_t;

    // opc_op = instr[15:11]
    function automatic kind_t decode(input logic [4:0] opc_op);
        kind_t k;
        k = K_ILL;
        if (opc_op[4:2] == OPC_ALU) begin
            k = (opc_op[1:0] == ALU_SUB) ? K_CMP : K_ALU;
        end else if (opc_op[4:2] == OPC_MOV) begin
            if (opc_op[1:0] == MOV_REG) k = K_MOVR;
            else if (opc_op[1:0] == MOV_IMM) k = K_MOVI;
        end
        return k;
    endfunction

    function automatic logic [N-1:0] shift_op(input logic [N-1:0] v, input logic [1:0] sh);
        logic [N-1:0] r;
        case (sh)
            SH_LSL1: r = {v[N-2:0], 1'b0};
            SH_LSR1: r = {1'b0, v[N-1:1]};
            SH_ASR1: r = {v[N-1], v[N-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_sequencer_reg_file.sv
// 8x16 register file: one synchronous write port, operand and debug combinational reads.
module reg_file_8x16
    import alu_seq_pkg::*;
(
    input  logic         clk,
    input  logic         i_reset,
    input  logic         i_we,
    input  logic [2:0]   i_waddr,
    input  logic [N-1:0] i_wdata,
    input  logic [2:0]   i_raddr,
    output logic [N-1:0] o_rdata,
    input  logic [2:0]   i_dbg_addr,
    output logic [N-1:0] o_dbg_data
);

    logic [N-1:0] r_mem [8];

    // NOTE: this array is reset because a reset must visibly clear every register; a plain RAM would not be.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 8; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata    = r_mem[i_raddr];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer: latches operands, drives the external ALU, writes back result or status.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  instr,
    output logic         busy,
    output logic         done,
    output logic         illegal,
    output logic [N-1:0] alu_ain,
    output logic [N-1:0] alu_bin,
    output logic [1:0]   alu_op,
    input  logic [N-1:0] alu_c,
    input  logic [2:0]   alu_status,
    output logic [2:0]   status,
    input  logic [2:0]   dbg_addr,
    output logic [N-1:0] dbg_data
);

    state_t       r_state, w_next;
    kind_t        r_kind, w_kind;
    logic [12:0]  r_ir;
    logic [N-1:0] r_a, r_b, r_c;
    logic [2:0]   r_status;
    logic         r_done, r_illegal;

    logic         w_accept, w_fin, w_we;
    logic [2:0]   w_waddr, w_raddr, w_flags;
    logic [N-1:0] w_wdata, w_rdata;

    assign w_kind   = decode(instr[15:11]);
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_flags  = {alu_status[ST_V], alu_status[ST_N], alu_status[ST_Z]};

    reg_file_8x16 u_rf (
        .clk        (clk),
        .i_reset    (reset),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_raddr    (w_raddr),
        .o_rdata    (w_rdata),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (w_kind)
                        K_ALU, K_CMP: w_next = S_GET_A;
                        K_MOVR:       w_next = S_GET_B;
                        K_MOVI:       w_next = S_WIMM;
                        default:      w_next = S_IDLE;
                    endcase
                end
            end
            S_GET_A: w_next = S_GET_B;
            S_GET_B: w_next = S_EXEC;
            S_EXEC:  w_next = (r_kind == K_CMP) ? S_IDLE : S_WRITE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != S_IDLE);
        alu_op  = ALU_ADD;
        w_raddr = (r_state == S_GET_A) ? r_ir[10:8] : r_ir[2:0];
        w_we    = 1'b0;
        w_waddr = r_ir[7:5];
        w_wdata = r_c;
        w_fin   = 1'b0;
        case (r_state)
            S_EXEC: begin
                w_fin = (r_kind == K_CMP);
                if (r_kind == K_CMP) begin
                    alu_op = ALU_SUB;
                end else if (r_kind == K_ALU) begin
                    case (r_ir[12:11])
                        ALU_AND:  alu_op = ALU_AND;
                        ALU_NOTB: alu_op = ALU_NOTB;
                        default:  alu_op = ALU_ADD;
                    endcase
                end
            end
            S_WRITE: begin
                w_we  = 1'b1;
                w_fin = 1'b1;
            end
            S_WIMM: begin
                w_we    = 1'b1;
                w_waddr = r_ir[10:8];
                w_wdata = {{(N-8){r_ir[7]}}, r_ir[7:0]};
                w_fin   = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir      <= '0;
            r_kind    <= K_ILL;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_status  <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done    <= w_fin || (w_accept && w_kind == K_ILL);
            r_illegal <= w_accept && w_kind == K_ILL;
            if (w_accept && w_kind != K_ILL) begin
                r_ir   <= instr[12:0];
                r_kind <= w_kind;
                if (w_kind == K_MOVR) r_a <= '0;
            end
            case (r_state)
                S_GET_A: r_a <= w_rdata;
                S_GET_B: r_b <= shift_op(w_rdata, r_ir[4:3]);
                S_EXEC: begin
                    r_c <= alu_c;
                    if (r_kind == K_CMP) r_status <= w_flags;
                end
                default: ;
            endcase
        end
    end

    assign done    = r_done;
    assign illegal = r_illegal;
    assign alu_ain = r_a;
    assign alu_bin = r_b;
    assign status  = r_status;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural 16-bit ALU attached.
`timescale 1ns/1ps
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] instr;
    logic        busy, done, illegal;
    logic [15:0] alu_ain, alu_bin, alu_c;
    logic [1:0]  alu_op;
    logic [2:0]  alu_status, status;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    int          lat, bcnt;
    logic        ill;
    logic [15:0] bin3;
    logic [1:0]  op3;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .instr      (instr),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal),
        .alu_ain    (alu_ain),
        .alu_bin    (alu_bin),
        .alu_op     (alu_op),
        .alu_c      (alu_c),
        .alu_status (alu_status),
        .status     (status),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Reference ALU: the sequencer's external combinational partner.
    always_comb begin
        logic [2:0] f;
        logic       v;
        v = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                alu_c = alu_ain + alu_bin;
                v = (alu_ain[15] == alu_bin[15]) && (alu_c[15] != alu_ain[15]);
            end
            ALU_SUB: begin
                alu_c = alu_ain - alu_bin;
                v = (alu_ain[15] != alu_bin[15]) && (alu_c[15] != alu_ain[15]);
            end
            ALU_AND: alu_c = alu_ain & alu_bin;
            default: alu_c = ~alu_bin;
        endcase
        f = '0;
        f[ST_Z] = (alu_c == 16'h0000);
        f[ST_N] = alu_c[15];
        f[ST_V] = v;
        alu_status = f;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_is(input string tag, input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #0.1;
        check(tag, dbg_data, exp);
    endtask

    // Issues one instruction and waits (bounded) for done; latency counts from the start-sampling edge.
    task automatic run(input logic [15:0] ins, output int l, output int b, output logic il,
                       output logic [15:0] bn, output logic [1:0] op);
        instr = ins;
        start = 1'b1;
        step();
        start = 1'b0;
        l = 1;
        b = 0;
        bn = 'x;
        op = 'x;
        while (done !== 1'b1 && l < 20) begin
            if (busy === 1'b1) b++;
            if (l == 3) begin
                bn = alu_bin;
                op = alu_op;
            end
            step();
            l++;
        end
        il = illegal;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        instr    = 16'h0000;
        dbg_addr = 3'd0;
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_alu_op", alu_op, 2'b00);
        check("rst_status", status, 3'b000);
        check("rst_ain", alu_ain, 16'h0000);
        check("rst_bin", alu_bin, 16'h0000);
        for (int i = 0; i < 8; i++) reg_is($sformatf("rst_r%0d", i), 3'(i), 16'h0000);

        // MOV R0,#7 then MOV R1,#-2
        run(16'hD007, lat, bcnt, ill, bin3, op3);
        check("movi0_lat", lat, 2);
        check("movi0_illegal", ill, 1'b0);
        run(16'hD1FE, lat, bcnt, ill, bin3, op3);
        check("movi1_lat", lat, 2);
        reg_is("movi_r0", 3'd0, 16'h0007);
        reg_is("movi_r1", 3'd1, 16'hFFFE);

        // ADD R2,R0,R1 LSL1: 7 + 0xFFFC wraps to 3
        run(16'hA049, lat, bcnt, ill, bin3, op3);
        check("add_lat", lat, 5);
        check("add_busy_cycles", bcnt, 4);
        check("add_exec_bin", bin3, 16'hFFFC);
        check("add_exec_op", op3, 2'b00);
        reg_is("add_r2", 3'd2, 16'h0003);
        check("add_status_kept", status, 3'b000);

        // CMP R0,R0: only Z set, no register write
        run(16'hA800, lat, bcnt, ill, bin3, op3);
        check("cmp_lat", lat, 4);
        check("cmp_exec_op", op3, 2'b01);
        check("cmp_status", status, 3'b001);
        reg_is("cmp_r0", 3'd0, 16'h0007);
        reg_is("cmp_r1", 3'd1, 16'hFFFE);
        reg_is("cmp_r2", 3'd2, 16'h0003);

        // AND R4,R2,R1: 3 & 0xFFFE = 2
        run(16'hB281, lat, bcnt, ill, bin3, op3);
        check("and_lat", lat, 5);
        check("and_exec_op", op3, 2'b10);
        reg_is("and_r4", 3'd4, 16'h0002);

        // Illegal 0x0000, then MOV R3,#5 issued in the done cycle
        run(16'h0000, lat, bcnt, ill, bin3, op3);
        check("ill_lat", lat, 1);
        check("ill_flag", ill, 1'b1);
        check("ill_busy_cycles", bcnt, 0);
        check("ill_status", status, 3'b001);
        run(16'hD305, lat, bcnt, ill, bin3, op3);
        check("b2b_lat", lat, 2);
        check("b2b_illegal_clear", ill, 1'b0);
        reg_is("b2b_r3", 3'd3, 16'h0005);
        reg_is("ill_r0", 3'd0, 16'h0007);
        reg_is("ill_r2", 3'd2, 16'h0003);

        // MVN R0,R0: ~7; status must not follow the ALU flags
        run(16'hB800, lat, bcnt, ill, bin3, op3);
        check("mvn_lat", lat, 5);
        check("mvn_exec_op", op3, 2'b11);
        reg_is("mvn_r0", 3'd0, 16'hFFF8);
        check("mvn_status_kept", status, 3'b001);

        // MOV R7,R1 with sh=10 (LSR1) then sh=11 (ASR1)
        run(16'hC0F1, lat, bcnt, ill, bin3, op3);
        check("movr_lsr_lat", lat, 4);
        check("movr_lsr_ain", alu_ain, 16'h0000);
        reg_is("movr_lsr_r7", 3'd7, 16'h7FFF);
        run(16'hC0F9, lat, bcnt, ill, bin3, op3);
        check("movr_asr_lat", lat, 4);
        reg_is("movr_asr_r7", 3'd7, 16'hFFFF);

        // ADD again, ignored start while busy, then reset in EXEC
        instr = 16'hA049;
        start = 1'b1;
        step();
        instr = 16'hD5AA;
        step();
        start = 1'b0;
        instr = 16'h0000;
        step();
        check("midrst_busy_exec", busy, 1'b1);
        check("midrst_exec_bin", alu_bin, 16'hFFFC);
        check("midrst_exec_op", alu_op, 2'b00);
        reset = 1'b1;
        #1;
        check("midrst_busy_async", busy, 1'b0);
        check("midrst_done_async", done, 1'b0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("midrst_no_done_%0d", i), done, 1'b0);
            step();
        end
        check("midrst_busy", busy, 1'b0);
        check("midrst_status", status, 3'b000);
        for (int i = 0; i < 8; i++) reg_is($sformatf("midrst_r%0d", i), 3'(i), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
